// File: rtl/mem_bus_arbiter.sv
// Round-robin NCH-channel byte-serial memory bus controller (RAM + IO).
// Define MEMBUS_CANCEL_EN to let rollback abort in-flight reads.
module mem_bus_arbiter #(
    parameter int              NCH         = 3,
    parameter int              ADDR_W      = 32,
    parameter logic [NCH-1:0]  CANCEL_MASK = {NCH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr,
    input  logic [NCH-1:0]        req_en,
    input  logic [NCH-1:0]        req_wr,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*3-1:0]      req_len,
    input  logic [NCH*32-1:0]     req_wdata,
    output logic [NCH-1:0]        done,
    output logic [31:0]           rdata
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_IOWAIT
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PW-1:0]     g_q, g_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [NCH-1:0]    done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              gnt_vld;
    logic [PW-1:0]     gnt_idx;
    logic [NCH-1:0]    elig;
    logic [ADDR_W-1:0] g_addr;
    logic [2:0]        g_len;
    logic [31:0]       g_wdata;
    logic              g_wr;

    logic [2:0]        cur_idx;
    logic [ADDR_W-1:0] cur_base;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] byte_addr;
    logic              byte_io;
    logic [7:0]        byte_val;
    logic [1:0]        rd_idx;
    logic              cancel;

    // First eligible channel at or after the round-robin pointer
    always_comb begin
        int j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        elig    = req_en & ~done_q;
        for (int i = NCH - 1; i >= 0; i--) begin
            j = (int'(rr_q) + i) % NCH;
            if (elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    assign g_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign g_len   = req_len[int'(gnt_idx)*3 +: 3];
    assign g_wdata = req_wdata[int'(gnt_idx)*32 +: 32];
    assign g_wr    = req_wr[gnt_idx];

    // Byte about to go on the bus: byte 0 of the grantee in IDLE, else byte cnt
    assign cur_idx   = (state_q == S_IDLE) ? 3'd0 : cnt_q;
    assign cur_base  = (state_q == S_IDLE) ? g_addr : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? g_wdata : wdata_q;
    assign byte_addr = cur_base + ADDR_W'(cur_idx);
    assign byte_io   = (byte_addr[17:16] == 2'b11);
    assign byte_val  = cur_wdata[{cur_idx[1:0], 3'b000} +: 8];
    assign rd_idx    = cnt_q[1:0] - 2'd1;

`ifdef MEMBUS_CANCEL_EN
    assign cancel = rollback && (state_q == S_READ) && CANCEL_MASK[g_q];
`else
    logic unused_rollback;
    assign unused_rollback = rollback;
    assign cancel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            g_q        <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            rr_q       <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            done_q     <= '0;
            rdata_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            g_q        <= g_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            rr_q       <= rr_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld && g_len != 3'd0) begin
                    if (!g_wr)
                        state_d = S_READ;
                    else if (byte_io && io_buffer_full)
                        state_d = S_IOWAIT;
                    else
                        state_d = S_WRITE;
                end
            end
            S_READ: begin
                if (cancel || cnt_q == len_q)
                    state_d = S_IDLE;
            end
            S_WRITE: begin
                if (cnt_q == len_q)
                    state_d = S_IDLE;
                else if (byte_io && io_buffer_full)
                    state_d = S_IOWAIT;
            end
            S_IOWAIT: begin
                if (!io_buffer_full)
                    state_d = S_WRITE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        g_d        = g_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        rr_d       = rr_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    g_d     = gnt_idx;
                    addr_d  = g_addr;
                    len_d   = g_len;
                    wdata_d = g_wdata;
                    rr_d    = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
                    rdata_d = '0;
                    if (g_len == 3'd0) begin
                        done_d[gnt_idx] = 1'b1;
                    end else if (!g_wr) begin
                        mem_a_d = g_addr;
                        cnt_d   = 3'd1;
                    end else if (byte_io && io_buffer_full) begin
                        cnt_d = 3'd0;
                    end else begin
                        mem_a_d    = g_addr;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = byte_val;
                        cnt_d      = 3'd1;
                    end
                end
            end
            S_READ: begin
                if (cancel) begin
                    mem_a_d = '0;
                end else begin
                    rdata_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == len_q) begin
                        done_d[g_q] = 1'b1;
                        mem_a_d     = '0;
                    end else begin
                        mem_a_d = byte_addr;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == len_q) begin
                    mem_wr_d    = 1'b0;
                    mem_a_d     = '0;
                    done_d[g_q] = 1'b1;
                end else if (byte_io && io_buffer_full) begin
                    // Park with the bus idle so the UART never sees a stray read
                    mem_wr_d = 1'b0;
                    mem_a_d  = '0;
                end else begin
                    mem_a_d    = byte_addr;
                    mem_dout_d = byte_val;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            S_IOWAIT: begin
                if (!io_buffer_full) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = byte_addr;
                    mem_dout_d = byte_val;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign done     = done_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// multi-channel batches checked against a byte-array / round-robin model.
module tb_mem_bus_arbiter;
    localparam int NCH = 3;

    logic            clk = 1'b0;
    logic            rst, rdy, rollback, io_buffer_full;
    logic [7:0]      mem_din, mem_dout;
    logic [31:0]     mem_a;
    logic            mem_wr;
    logic [NCH-1:0]  req_en, req_wr, done;
    logic [NCH*32-1:0] req_addr, req_wdata;
    logic [NCH*3-1:0]  req_len;
    logic [31:0]     rdata;

    mem_bus_arbiter #(.NCH(NCH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:131071];
    logic [7:0] mdl [0:131071];
    logic [7:0] io_q [$];
    int tests = 0;
    int fails = 0;
    int model_rr = 0;

    logic        op_wr   [NCH];
    logic [31:0] op_addr [NCH];
    logic [2:0]  op_len  [NCH];
    logic [31:0] op_wd   [NCH];

    // IO space reads return a fixed byte
    assign mem_din = (mem_a[17:16] == 2'b11) ? 8'h5A : ram[mem_a[16:0]];

    always @(posedge clk) begin
        if (mem_wr && rdy && !rst) begin
            if (mem_a[17:16] == 2'b11) io_q.push_back(mem_dout);
            else ram[mem_a[16:0]] = mem_dout;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int c, input logic wr, input logic [31:0] a,
                          input logic [2:0] len, input logic [31:0] wd);
        op_wr[c] = wr; op_addr[c] = a; op_len[c] = len; op_wd[c] = wd;
    endtask

    task automatic drive(input int c);
        req_wr[c] = op_wr[c];
        req_addr[c*32 +: 32] = op_addr[c];
        req_len[c*3 +: 3] = op_len[c];
        req_wdata[c*32 +: 32] = op_wd[c];
    endtask

    function automatic logic [31:0] exp_rd(input int c);
        logic [31:0] v, a;
        v = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(op_len[c])) begin
                a = op_addr[c] + 32'(b);
                v[8*b +: 8] = (a[17:16] == 2'b11) ? 8'h5A : mdl[a[16:0]];
            end
        end
        return v;
    endfunction

    // Issue all channels in mask at once; service order follows round-robin rule
    task automatic batch(input logic [NCH-1:0] mask, input int exp_lat,
                         input int frz, input int io_n, input int exp_wr_hi);
        int order[$];
        logic [7:0] exp_io[$];
        logic [NCH-1:0] pend;
        logic [31:0] a;
        logic [7:0] bt;
        int r, j, n, k, c, wr_hi, io0;
        pend = mask;
        r = model_rr;
        while (pend != 0) begin
            for (int i = 0; i < NCH; i++) begin
                j = (r + i) % NCH;
                if (pend[j]) begin
                    order.push_back(j);
                    pend[j] = 1'b0;
                    r = (j + 1) % NCH;
                    break;
                end
            end
        end
        model_rr = r;
        @(posedge clk); #1;
        io0 = io_q.size();
        for (int i = 0; i < NCH; i++) if (mask[i]) drive(i);
        req_en = req_en | mask;
        io_buffer_full = (io_n > 0);
        n = 0; k = 0; wr_hi = 0;
        while (k < order.size() && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == frz) rdy = 1'b0;
            if (frz > 0 && n == frz + 2) rdy = 1'b1;
            if (n == io_n) io_buffer_full = 1'b0;
            if (mem_wr) wr_hi++;
            if (done != 0) begin
                c = order[k];
                chk("done_onehot", done, NCH'(1) << c);
                if (k == 0 && exp_lat > 0) chk("latency", n, exp_lat);
                if (!op_wr[c]) chk("rdata", rdata, exp_rd(c));
                req_en[c] = 1'b0;
                k++;
            end
        end
        io_buffer_full = 1'b0;
        chk("all_served", k, order.size());
        if (exp_wr_hi >= 0) chk("wr_cycles", wr_hi, exp_wr_hi);
        for (int i = 0; i < order.size(); i++) begin
            c = order[i];
            if (op_wr[c]) begin
                for (int b = 0; b < int'(op_len[c]); b++) begin
                    a = op_addr[c] + 32'(b);
                    bt = op_wd[c][8*b +: 8];
                    if (a[17:16] == 2'b11) exp_io.push_back(bt);
                    else begin
                        mdl[a[16:0]] = bt;
                        chk("wr_byte", ram[a[16:0]], bt);
                    end
                end
            end
        end
        chk("io_count", io_q.size() - io0, exp_io.size());
        for (int i = 0; i < exp_io.size(); i++)
            if (io0 + i < io_q.size()) chk("io_byte", io_q[io0 + i], exp_io[i]);
    endtask

    initial begin
        logic [7:0] v;
        logic [NCH-1:0] m;
        for (int i = 0; i < 131072; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            mdl[i] = v;
        end
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        req_en = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);

        // Contention and round-robin order
        set_op(0, 1'b0, 32'h300, 3'd2, 0);
        set_op(2, 1'b0, 32'h500, 3'd3, 0);
        batch(3'b101, 3, 0, 0, -1);
        set_op(0, 1'b0, 32'h310, 3'd1, 0);
        batch(3'b001, 2, 0, 0, -1);
        set_op(0, 1'b0, 32'h320, 3'd4, 0);
        set_op(2, 1'b0, 32'h520, 3'd4, 0);
        batch(3'b101, 5, 0, 0, -1);

        // Four-byte read
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        mdl[32'h100] = 8'h11; mdl[32'h101] = 8'h22;
        mdl[32'h102] = 8'h33; mdl[32'h103] = 8'h44;
        set_op(1, 1'b0, 32'h100, 3'd4, 0);
        batch(3'b010, 5, 0, 0, -1);
        chk("t1_rdata", rdata, 32'h44332211);

        set_op(2, 1'b1, 32'h200, 3'd4, 32'hDEADBEEF);
        batch(3'b100, 5, 0, 0, 4);
        chk("t3_byte0", ram[32'h200], 8'hEF);
        chk("t3_byte3", ram[32'h203], 8'hDE);

        // IO write held off by a full UART buffer
        set_op(1, 1'b1, 32'h30000, 3'd1, 32'h41);
        batch(3'b010, 5, 0, 3, 1);
        // IO reads ignore the buffer-full flag
        set_op(0, 1'b0, 32'h30004, 3'd1, 0);
        batch(3'b001, 2, 0, 3, -1);
        // Address wrap: byte 0 at top of space (IO), byte 1 at 0
        set_op(2, 1'b1, 32'hFFFFFFFF, 3'd2, 32'hABCD);
        batch(3'b100, 3, 0, 0, 2);
        // Zero-length transfers
        set_op(0, 1'b1, 32'h500, 3'd0, 32'h12345678);
        batch(3'b001, 1, 0, 0, 0);
        set_op(1, 1'b0, 32'h500, 3'd0, 0);
        batch(3'b010, 1, 0, 0, -1);

        // Freeze mid-read
        ram[32'h10] = 8'hAA; ram[32'h11] = 8'hBB;
        mdl[32'h10] = 8'hAA; mdl[32'h11] = 8'hBB;
        set_op(1, 1'b0, 32'h10, 3'd2, 0);
        batch(3'b010, 5, 1, 0, -1);
        chk("t6_rdata", rdata, 32'hBBAA);

        // Rollback during a read
        @(posedge clk); #1;
        set_op(0, 1'b0, 32'h100, 3'd4, 0);
        drive(0);
        req_en[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_rr = 1;
        rollback = 1'b1;
        @(posedge clk); #1;
        rollback = 1'b0;
`ifdef MEMBUS_CANCEL_EN
        req_en[0] = 1'b0;
        chk("rb_no_done", done, 0);
        chk("rb_mem_a", mem_a, 0);
        set_op(1, 1'b0, 32'h40, 3'd2, 0);
        batch(3'b010, 3, 0, 0, -1);
`else
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rb_done", done, 3'b001);
        chk("rb_rdata", rdata, 32'h44332211);
        req_en[0] = 1'b0;
`endif

        // Reset mid-transfer aborts and restarts the round-robin pointer
        @(posedge clk); #1;
        set_op(1, 1'b0, 32'h100, 3'd4, 0);
        drive(1);
        req_en[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_en = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_done", done, 0);
        chk("mrst_mem_a", mem_a, 0);
        chk("mrst_rdata", rdata, 0);
        @(posedge clk); #1;
        chk("mrst_no_done", done, 0);
        model_rr = 0;
        set_op(0, 1'b0, 32'h600, 3'd1, 0);
        set_op(2, 1'b0, 32'h700, 3'd1, 0);
        batch(3'b101, 2, 0, 0, -1);

        for (int t = 0; t < 25; t++) begin
            m = NCH'($urandom_range(1, 7));
            for (int c = 0; c < NCH; c++)
                set_op(c, 1'($urandom), 32'(c * 32'h4000 + $urandom_range(0, 32'h3FF0)),
                       3'($urandom_range(0, 4)), $urandom);
            batch(m, 0, 0, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
